// File: rtl/control_unit_if.sv
// Memory-side handshake bundle for control_unit: instruction fetch port and data-memory strobes.
// The sequencer is the master; the memory system (or a bench) is the slave.
interface control_unit_if;
  logic [5:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_addr, imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_data, dmem_ack
  );

  modport slave (
    input  imem_addr, imem_req, dmem_req, dmem_we,
    output imem_ack, imem_data, dmem_ack
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving datapath controls.
// Owns the 6-bit PC and the instruction register; memory handshakes travel over control_unit_if.
module control_unit (
  input  logic                  clk_main,
  input  logic                  reset,
  control_unit_if.master        mem,
  input  logic [15:0]           BusA,
  input  logic                  Z,
  output logic [3:0]            DR,
  output logic [3:0]            SA,
  output logic [3:0]            SB,
  output logic [3:0]            FS,
  output logic [5:0]            PC,
  output logic                  MB,
  output logic                  MD,
  output logic                  RW,
  output logic                  MP,
  output logic                  halted
);

  localparam logic [3:0] FS_PASSA = 4'hF;
  localparam logic [3:0] FS_PASSB = 4'hE;

  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JAL  = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_LDI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [5:0]  r_pc;
  logic [5:0]  w_nextPc;
  logic [15:0] r_ir;
  logic [15:0] w_nextIr;
  logic [3:0]  w_op;
  logic [5:0]  w_bzOffset;
  logic        w_unusedBusA;

  assign w_op         = r_ir[15:12];
  assign w_bzOffset   = {{2{r_ir[11]}}, r_ir[11:8]};
  assign w_unusedBusA = ^BusA[15:6];

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= 6'd0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_ir    <= w_nextIr;
    end
  end

  // Register fields and ALU select come straight from IR so they stay stable through EXEC.
  assign DR            = r_ir[11:8];
  assign SA            = r_ir[7:4];
  assign SB            = r_ir[3:0];
  assign MB            = (w_op == OP_LDI);
  assign PC            = r_pc;
  assign mem.imem_addr = r_pc;

  always_comb begin
    FS = 4'h0;
    if (!w_op[3]) begin
      FS = {1'b0, w_op[2:0]};
    end else if (w_op == OP_BZ) begin
      FS = FS_PASSA;
    end else if (w_op == OP_LDI) begin
      FS = FS_PASSB;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextIr     = r_ir;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    RW           = 1'b0;
    MD           = 1'b0;
    MP           = 1'b0;
    halted       = 1'b0;
    case (r_state)
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          w_nextIr    = mem.imem_data;
          w_nextPc    = r_pc + 6'd1;
          w_nextState = DECODE;
        end
      end
      DECODE: w_nextState = EXEC;
      EXEC: begin
        w_nextState = FETCH;
        case (w_op)
          OP_LD: begin
            MD           = 1'b1;
            mem.dmem_req = 1'b1;
            RW           = mem.dmem_ack;
            if (!mem.dmem_ack) w_nextState = EXEC;
          end
          OP_ST: begin
            mem.dmem_req = 1'b1;
            mem.dmem_we  = 1'b1;
            if (!mem.dmem_ack) w_nextState = EXEC;
          end
          // Link value is the already-incremented PC; the jump lands on the same edge.
          OP_JAL: begin
            MP       = 1'b1;
            RW       = 1'b1;
            w_nextPc = BusA[5:0];
          end
          OP_BZ: begin
            if (Z) w_nextPc = r_pc + w_bzOffset;
          end
          OP_JMP:  w_nextPc = r_ir[5:0];
          OP_LDI:  RW = 1'b1;
          OP_NOP:  w_nextState = FETCH;
          OP_HALT: w_nextState = HALT;
          default: RW = 1'b1;
        endcase
      end
      HALT: halted = 1'b1;
      default: w_nextState = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against an instruction-level behavioural model.
// A driver walks each instruction through its cycles; one compare process checks every cycle.
module tb_control_unit;

  logic        clk_main = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] BusA     = 16'h0000;
  logic        Z        = 1'b0;
  logic [3:0]  DR, SA, SB, FS;
  logic [5:0]  PC;
  logic        MB, MD, RW, MP, halted;

  control_unit_if bus ();

  control_unit dut (
    .clk_main (clk_main),
    .reset    (reset),
    .mem      (bus),
    .BusA     (BusA),
    .Z        (Z),
    .DR       (DR),
    .SA       (SA),
    .SB       (SB),
    .FS       (FS),
    .PC       (PC),
    .MB       (MB),
    .MD       (MD),
    .RW       (RW),
    .MP       (MP),
    .halted   (halted)
  );

  always #5 clk_main = ~clk_main;

  typedef struct {
    logic       imemReq;
    logic [5:0] imemAddr;
    logic       dmemReq;
    logic       dmemWe;
    logic       rw;
    logic       mb;
    logic       md;
    logic       mp;
    logic       halted;
    logic [3:0] fs;
    logic [3:0] dr;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [5:0] pc;
  } exp_t;

  exp_t        e;
  bit          expValid = 0;
  logic [5:0]  mPc = 6'd0;
  logic [15:0] mIr = 16'h0000;
  bit          mHalted = 0;
  int          nChecks = 0;
  int          nFails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic logic [3:0] fsOf(input logic [3:0] op);
    if (op < 4'h8) return op;
    if (op == 4'hB) return 4'hF;
    if (op == 4'hD) return 4'hE;
    return 4'h0;
  endfunction

  // Expected outputs when nothing instruction-specific is active this cycle.
  function automatic void baseExp();
    e.imemReq  = 1'b0;
    e.imemAddr = mPc;
    e.pc       = mPc;
    e.dmemReq  = 1'b0;
    e.dmemWe   = 1'b0;
    e.rw       = 1'b0;
    e.md       = 1'b0;
    e.mp       = 1'b0;
    e.halted   = 1'b0;
    e.dr       = mIr[11:8];
    e.sa       = mIr[7:4];
    e.sb       = mIr[3:0];
    e.fs       = fsOf(mIr[15:12]);
    e.mb       = (mIr[15:12] == 4'hD);
  endfunction

  task automatic checkOutput();
    check("imem_req",  32'(bus.imem_req),  32'(e.imemReq));
    check("imem_addr", 32'(bus.imem_addr), 32'(e.imemAddr));
    check("dmem_req",  32'(bus.dmem_req),  32'(e.dmemReq));
    check("dmem_we",   32'(bus.dmem_we),   32'(e.dmemWe));
    check("RW",        32'(RW),            32'(e.rw));
    check("MB",        32'(MB),            32'(e.mb));
    check("MD",        32'(MD),            32'(e.md));
    check("MP",        32'(MP),            32'(e.mp));
    check("halted",    32'(halted),        32'(e.halted));
    check("FS",        32'(FS),            32'(e.fs));
    check("DR",        32'(DR),            32'(e.dr));
    check("SA",        32'(SA),            32'(e.sa));
    check("SB",        32'(SB),            32'(e.sb));
    check("PC",        32'(PC),            32'(e.pc));
  endtask

  always @(negedge clk_main) begin
    if (expValid) checkOutput();
  end

  task automatic randomInputs();
    bus.imem_ack  = 1'($urandom);
    bus.imem_data = 16'($urandom);
    bus.dmem_ack  = 1'($urandom);
    Z             = 1'($urandom);
    BusA          = 16'($urandom);
  endtask

  task automatic doReset(input bit waitEdge);
    if (waitEdge) @(posedge clk_main);
    #2;
    expValid = 0;
    reset    = 1'b1;
    #1;
    check("reset imem_req",  32'(bus.imem_req),  32'd1);
    check("reset imem_addr", 32'(bus.imem_addr), 32'd0);
    check("reset dmem_req",  32'(bus.dmem_req),  32'd0);
    check("reset dmem_we",   32'(bus.dmem_we),   32'd0);
    check("reset RW",        32'(RW),            32'd0);
    check("reset PC",        32'(PC),            32'd0);
    check("reset FS",        32'(FS),            32'd0);
    check("reset DR",        32'(DR),            32'd0);
    check("reset MB/MD/MP",  32'({MB, MD, MP}),  32'd0);
    check("reset halted",    32'(halted),        32'd0);
    @(posedge clk_main);
    #1;
    reset    = 1'b0;
    mPc      = 6'd0;
    mIr      = 16'h0000;
    mHalted  = 0;
    randomInputs();
    bus.imem_ack = 1'b0;
    baseExp();
    e.imemReq = 1'b1;
    expValid  = 1;
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input int iw);
    for (int k = 0; k <= iw; k++) begin
      @(posedge clk_main);
      #1;
      randomInputs();
      bus.imem_ack = (k == iw);
      if (k == iw) bus.imem_data = instr;
      baseExp();
      e.imemReq = 1'b1;
    end
    mIr = instr;
    mPc = mPc + 6'd1;
    @(posedge clk_main);
    #1;
    randomInputs();
    baseExp();
  endtask

  task automatic execute(input int dw, input int zForce, input int busForce);
    logic [3:0] op;
    int off;
    op = mIr[15:12];
    if (op == 4'h8 || op == 4'h9) begin
      for (int k = 0; k <= dw; k++) begin
        @(posedge clk_main);
        #1;
        randomInputs();
        bus.dmem_ack = (k == dw);
        baseExp();
        e.dmemReq = 1'b1;
        e.dmemWe  = (op == 4'h9);
        e.md      = (op == 4'h8);
        e.rw      = (op == 4'h8) && (k == dw);
      end
    end else begin
      @(posedge clk_main);
      #1;
      randomInputs();
      if (zForce >= 0) Z = zForce[0];
      if (busForce >= 0) BusA = busForce[15:0];
      baseExp();
      if (op < 4'h8 || op == 4'hD) e.rw = 1'b1;
      if (op == 4'hA) begin
        e.rw = 1'b1;
        e.mp = 1'b1;
        mPc  = BusA[5:0];
      end
      if (op == 4'hB && Z) begin
        off = (mIr[11:8] >= 4'h8) ? int'(mIr[11:8]) - 16 : int'(mIr[11:8]);
        mPc = 6'((int'(mPc) + off + 64) % 64);
      end
      if (op == 4'hC) mPc = mIr[5:0];
      if (op == 4'hF) mHalted = 1;
    end
  endtask

  task automatic runHalt(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_main);
      #1;
      randomInputs();
      baseExp();
      e.halted = 1'b1;
    end
  endtask

  // Inserts one non-acked fetch cycle so the fetch address can be pinned to a literal.
  task automatic peekFetchAddr(input logic [5:0] addr);
    @(posedge clk_main);
    #1;
    randomInputs();
    bus.imem_ack = 1'b0;
    baseExp();
    e.imemReq = 1'b1;
    #1;
    check("fetch addr literal", 32'(bus.imem_addr), 32'(addr));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] instr;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.dmem_ack  = 1'b0;

    doReset(1);
    #1;
    check("first fetch addr", 32'(bus.imem_addr), 32'd0);

    applyStimulus(16'h1213, 0);
    execute(0, -1, -1);
    #1;
    check("ALU DR", 32'(DR), 32'd2);
    check("ALU SA", 32'(SA), 32'd1);
    check("ALU SB", 32'(SB), 32'd3);
    check("ALU FS", 32'(FS), 32'd1);
    check("ALU RW", 32'(RW), 32'd1);
    check("ALU PC", 32'(PC), 32'd1);

    applyStimulus(16'h8123, 1);
    execute(3, -1, -1);

    applyStimulus(16'hC004, 0);
    execute(0, -1, -1);
    applyStimulus(16'hBE00, 0);
    #1;
    check("BZ PC after fetch", 32'(PC), 32'd5);
    execute(0, 1, -1);
    peekFetchAddr(6'd3);

    applyStimulus(16'hC004, 0);
    execute(0, -1, -1);
    applyStimulus(16'hBE00, 0);
    execute(0, 0, -1);
    peekFetchAddr(6'd5);

    applyStimulus(16'hC03F, 0);
    execute(0, -1, -1);
    applyStimulus(16'hA500, 2);
    execute(0, -1, 16'h0010);
    #1;
    check("JAL MP", 32'(MP), 32'd1);
    check("JAL RW", 32'(RW), 32'd1);
    check("JAL link PC", 32'(PC), 32'd0);
    peekFetchAddr(6'd16);

    applyStimulus(16'h9123, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_main);
      #1;
      randomInputs();
      bus.dmem_ack = 1'b0;
      baseExp();
      e.dmemReq = 1'b1;
      e.dmemWe  = 1'b1;
    end
    doReset(0);
    peekFetchAddr(6'd0);

    applyStimulus(16'hF000, 0);
    execute(0, -1, -1);
    runHalt(6);
    #1;
    check("HALT halted", 32'(halted), 32'd1);
    check("HALT imem_req", 32'(bus.imem_req), 32'd0);
    doReset(1);

    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
      instr = {op, 12'($urandom)};
      applyStimulus(instr, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      execute(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), -1, -1);
      if (mHalted) begin
        runHalt(3);
        doReset(1);
      end
    end

    @(posedge clk_main);
    #1;
    expValid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer that drives the control inputs of `datapath` (DR, SA, SB, FS, PC, MB, MD, RW, MP). It owns the 6-bit program counter and instruction register, fetches from instruction memory over a req/ack handshake, and sequences data-memory accesses. The datapath's `AddrOut`, `DataOut` and `DataIn` connect to data memory directly. This block only issues the data-memory request and write strobe.

## Interface
- `FS_PASSA`, 4'hF, ALU function code that passes A; driven during BZ so `Z` reflects R[SA].
- `FS_PASSB`, 4'hE, ALU function code that passes B; driven during LDI.
- `clk_main` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_addr` out 6: fetch address; equals the PC register.
- `imem_req` out 1: fetch request.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_data` in 16: instruction word.
- `dmem_req` out 1: data-memory request.
- `dmem_we` out 1: data-memory write, valid with `dmem_req`.
- `dmem_ack` in 1: data access complete this cycle.
- `BusA` in 16: datapath A bus, used as the JAL target.
- `Z` in 1: datapath zero flag.
- `DR`, `SA`, `SB` out 4 each: IR[11:8], IR[7:4], IR[3:0].
- `FS` out 4: ALU function.
- `PC` out 6: PC register, used as the link value for the datapath P mux.
- `MB`, `MD`, `RW`, `MP` out 1 each: datapath mux selects and register write.
- `halted` out 1: high in HALT.

## Operation
- Instruction format: [15:12] op, [11:8] DR, [7:4] SA, [3:0] SB.
- States: FETCH, DECODE, EXEC, HALT. Reset enters FETCH.
- FETCH: `imem_req`=1.
  - When `imem_ack`=1: IR <= `imem_data`, PC <= PC+1 (6-bit, 63 wraps to 0), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no side effects; control outputs settle from IR.
- EXEC, by op:
  - 0x0–0x7, ALU: FS={0,op[2:0]}, MB=0, MD=0, MP=0, RW=1 for one cycle, then FETCH.
  - 0x8, LD: MD=1, `dmem_req`=1, `dmem_we`=0. Hold until `dmem_ack`. RW=1 only in the ack cycle, then FETCH.
  - 0x9, ST: `dmem_req`=1, `dmem_we`=1, RW=0. Hold until `dmem_ack`, then FETCH.
  - 0xA, JAL: MP=1, RW=1 (writes incremented PC into R[DR]). PC <= `BusA`[5:0], then FETCH.
  - 0xB, BZ: FS=`FS_PASSA`. If `Z`=1, PC <= PC + sign-extend(IR[11:8]) mod 64. RW=0, then FETCH.
  - 0xC, JMP: PC <= IR[5:0], then FETCH.
  - 0xD, LDI: MB=1, FS=`FS_PASSB`, RW=1, then FETCH.
  - 0xE, NOP: go to FETCH.
  - 0xF, HALT: go to HALT.
- HALT: absorbing; `halted`=1. Only `reset` exits.
- Outside EXEC: RW=0, `dmem_req`=0, `dmem_we`=0, MP=0, MD=0.
- DR, SA, SB, FS and MB are decoded from IR and held through EXEC.

## Timing
- Reset values: PC=0, IR=0, state=FETCH. Outputs during reset: `imem_req`=1, `imem_addr`=0, RW=0, `dmem_req`=0, `dmem_we`=0, MB=MD=MP=0, FS=0, DR=SA=SB=0, `halted`=0.
- With zero-wait ack, every instruction takes 3 cycles: FETCH, DECODE, EXEC.
- Each wait cycle on `imem_ack` or `dmem_ack` adds one cycle.
- `imem_req`/`dmem_req` stay high and addresses stay stable until the ack is sampled.
- An ack outside the matching request window is ignored.
- RW is asserted for exactly one cycle per register-writing instruction.
- PC and IR update on the clock edge that leaves the state.
- During DECODE/EXEC, `PC` already holds the incremented value.
- JAL: link write (old PC+1) and the PC load happen on the same edge, so the link value is the pre-jump PC.
- Reset asserted mid-handshake: all state clears immediately. The pending request drops, and no RW or `dmem_we` pulse completes.

## Test plan
- Reset release, then `imem_data`=16'h1213 with immediate ack → `imem_addr`=0 in cycle 1. DR=2, SA=1, SB=3, FS=1, RW=1 only in cycle 3. PC=1 thereafter.
- LD with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_we`=0, MD=1 throughout. RW=1 only in the ack cycle.
- BZ offset 4'hE (−2) at PC=5 after fetch, `Z`=1 → next `imem_addr`=3. Same with `Z`=0 → next `imem_addr`=5.
- JAL at address 63 with `BusA`=16'h0010 → MP=1, RW=1, PC output 0 (wrapped link) during EXEC. Next fetch address 16.
- Reset pulsed while ST waits for `dmem_ack` → `dmem_req` and `dmem_we` drop asynchronously. PC=0, and the next fetch is from 0.
- Op 0xF → `halted`=1 and `imem_req`=0 permanently. Later acks are ignored until reset.
